// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word type plus fetch-stage state, entry and constants
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [1:0] {REQ, OUT, DRAIN} fetch_state_t;
  typedef struct packed {
    rv32i_word pc;
    rv32i_word ir;
  } fetch_entry_t;
  localparam rv32i_word RESET_PC_DEFAULT = 32'h0000_0060;
  localparam rv32i_word NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry {pc, ir} FIFO with flush; exists only when IF_PREFETCH_EN is defined
`ifdef IF_PREFETCH_EN
module fetch_buffer
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);
  fetch_entry_t mem_q [2];
  logic wr_q, rd_q, push_ok, pop_ok;
  logic [1:0] cnt_q;
  assign full_o = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign push_ok = push_i & ~full_o;
  assign pop_ok = pop_i & ~empty_o;
  assign head_o = mem_q[rd_q];
  // pointers and occupancy; a flush empties the FIFO without touching storage
  always_ff @(posedge clk) begin
    if (rst | flush_i) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_q] <= entry_i;
      wr_q <= wr_q ^ push_ok;
      rd_q <= rd_q ^ pop_ok;
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end; define IF_PREFETCH_EN for a 2-entry prefetch buffer
module fetch_unit
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = RESET_PC_DEFAULT,
  parameter rv32i_word NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  fetch_state_t state_q, state_d;
  rv32i_word pc_q, addr_q, target;
  logic run_q, resp, redir, accept;
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign resp = imem_resp & imem_read;
  assign redir = redirect & run_q;
  assign accept = resp & ~redir & (state_q == REQ);
  assign imem_address = (state_q == DRAIN) ? addr_q : pc_q;
  // state register; run_q keeps the request line quiet during reset and the cycle it is released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
    end
  end
  // fetch pointer: redirect wins, otherwise advance on each accepted response; addr_q freezes while draining
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (state_q != DRAIN) addr_q <= pc_q;
      pc_q <= redir ? target : accept ? pc_q + 32'd4 : pc_q;
    end
  end
`ifdef IF_PREFETCH_EN
  fetch_entry_t head, entry;
  logic full, empty;
  assign entry = '{pc: pc_q, ir: imem_rdata};
  // next state: only an abandoned in-flight request sends us to DRAIN
  always_comb begin
    state_d = (redir & imem_read & ~resp) ? DRAIN : (state_q == DRAIN && resp) ? REQ : state_q;
  end
  // outputs: keep requesting while the buffer has room, present the buffer head
  always_comb begin
    imem_read = run_q & ((state_q == DRAIN) | ~full);
    ir_valid = ~empty;
    ir_out = empty ? NOP_WORD : head.ir;
    pc_out = empty ? 32'd0 : head.pc;
  end
  fetch_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .flush_i(redir),
    .push_i(accept),
    .pop_i(ir_ready),
    .entry_i(entry),
    .head_o(head),
    .full_o(full),
    .empty_o(empty)
  );
`else
  rv32i_word ir_q, pco_q;
  // next state: REQ -> OUT on response, OUT -> REQ on handshake, redirect overrides
  always_comb begin
    state_d = (state_q == OUT) ? ((redir | ir_ready) ? REQ : OUT)
            : (state_q == DRAIN) ? (resp ? REQ : DRAIN)
            : redir ? (resp ? REQ : DRAIN) : (resp ? OUT : REQ);
  end
  // outputs: request outside OUT, present the held instruction only in OUT
  always_comb begin
    imem_read = run_q & (state_q != OUT);
    ir_valid = state_q == OUT;
    ir_out = ir_valid ? ir_q : NOP_WORD;
    pc_out = ir_valid ? pco_q : 32'd0;
  end
  // capture the returned instruction with the pc it was fetched from
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= NOP_WORD;
      pco_q <= 32'd0;
    end else if (accept) begin
      ir_q <= imem_rdata;
      pco_q <= pc_q;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch bench with a stream-level reference model and scoreboard
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_read, imem_resp = 1'b0, ir_valid, ir_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_address, imem_rdata = '0, ir_out, pc_out, redirect_pc = '0;
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_fetch = 32'h60, m_old = '0;
  bit m_drain = 0, p_rst = 0, p_acc = 0, p_hs = 0, p_rdx = 0;
  logic o_read, o_valid;
  logic [31:0] o_addr, o_ir, o_pc;
  int wait_cnt = 0, lat = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .ir_out(ir_out), .pc_out(pc_out),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h60) ? 32'h0050_0093 : ({a[15:0], a[31:16]} ^ 32'hC0DE_0013);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // one cycle: observe outputs, check against the model, then drive inputs and advance the model
  task automatic drive(input bit r, input int rs_mode, input bit rdir, input logic [31:0] t, input bit rdy);
    bit resp, rdx, acc, was_drain;
    @(negedge clk);
    o_read = imem_read; o_valid = ir_valid; o_addr = imem_address; o_ir = ir_out; o_pc = pc_out;
    if (p_rst) begin
      chk("rst_read", {31'd0, o_read}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ir", o_ir, 32'h13);
      chk("rst_pc", o_pc, 32'd0);
    end
    if (p_acc) chk("resp_to_valid", {31'd0, o_valid}, 32'd1);
    if (p_rdx) chk("redirect_drops_valid", {31'd0, o_valid}, 32'd0);
`ifndef IF_PREFETCH_EN
    if (p_acc) chk("no_read_while_valid", {31'd0, o_read}, 32'd0);
    if (p_hs) chk("hs_to_read", {31'd0, o_read}, 32'd1);
    chk("read_valid_exclusive", {31'd0, o_read & o_valid}, 32'd0);
`endif
    if (o_read) chk("imem_address", o_addr, m_drain ? m_old : m_fetch);
    resp = 0;
    if (o_read && !r) begin
      if (rs_mode == 1) resp = 1;
      else if (rs_mode == 2) begin
        if (wait_cnt >= lat) begin
          resp = 1;
          wait_cnt = 0;
          lat = $urandom_range(0, 3);
        end else wait_cnt++;
      end
    end
    if (!o_read || r) wait_cnt = 0;
    rdx = rdir && !r && (o_read || o_valid);
    rst = r; imem_resp = resp; imem_rdata = resp ? word(o_addr) : $urandom;
    redirect = rdx; redirect_pc = t; ir_ready = rdy;
    acc = resp && !rdx && !m_drain;
    if (r) begin
      m_fetch = 32'h60; m_drain = 0; sb.delete();
    end else begin
      was_drain = m_drain;
      if (rdx) sb.delete();
      if (acc) begin
        sb.push_back('{m_fetch, word(m_fetch)});
        m_fetch += 32'd4;
      end
      if (resp) m_drain = 0;
      if (rdx) begin
        if (o_read && !resp && !was_drain) begin
          m_old = m_fetch;
          m_drain = 1;
        end
        m_fetch = t & 32'hFFFF_FFFC;
      end
    end
    p_rst = r; p_acc = acc; p_hs = o_valid && rdy && !rdx && !r; p_rdx = rdx;
  endtask

  // monitor: every accepted handshake must match the head of the expected stream
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!ir_valid) chk("idle_ir_nop", ir_out, 32'h13);
    else if (ir_ready && !redirect && !rst) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_instr actual pc=%08h expected none", pc_out);
      end else begin
        e = sb.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("ir_out", ir_out, e.ir);
      end
    end
  end

  initial begin
    logic [31:0] h_ir, h_pc;
    drive(1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("t1_read", {31'd0, o_read}, 32'd1);
    chk("t1_addr", o_addr, 32'h60);
    drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("t1_ir", o_ir, 32'h0050_0093);
    chk("t1_pc", o_pc, 32'h60);
    h_ir = o_ir; h_pc = o_pc;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, i == 4);
      chk("t2_ir_stable", o_ir, h_ir);
      chk("t2_pc_stable", o_pc, h_pc);
      chk("t2_valid_held", {31'd0, o_valid}, 32'd1);
`ifndef IF_PREFETCH_EN
      chk("t2_no_read", {31'd0, o_read}, 32'd0);
`endif
    end
    drive(0, 0, 1, 32'h103, 0);
    chk("t2_next_read", {31'd0, o_read}, 32'd1);
    chk("t1_next_addr", o_addr, 32'h64);
    drive(0, 0, 0, 0, 0);
    chk("t3_drain_addr", o_addr, 32'h64);
    chk("t3_drain_read", {31'd0, o_read}, 32'd1);
    drive(0, 1, 0, 0, 0);
    chk("t3_drain_addr2", o_addr, 32'h64);
    drive(0, 1, 0, 0, 0);
    chk("t3_new_addr", o_addr, 32'h100);
    chk("t3_no_valid", {31'd0, o_valid}, 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("t3_pc", o_pc, 32'h100);
    drive(0, 1, 1, 32'h200, 0);
    drive(0, 1, 1, 32'hFFFF_FFFF, 0);
    chk("t4_addr", o_addr, 32'h200);
    chk("t4_no_valid", {31'd0, o_valid}, 32'd0);
    drive(0, 1, 0, 0, 0);
    chk("t5_addr", o_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1);
    chk("t5_pc", o_pc, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0);
    chk("t5_wrap_addr", o_addr, 32'h0);
    drive(0, 0, 0, 0, 1);
    chk("t5_wrap_pc", o_pc, 32'h0);
    drive(0, 0, 1, 32'h300, 0);
    drive(1, 0, 0, 0, 0);
    chk("t6_drain_addr", o_addr, 32'h4);
    drive(0, 0, 0, 0, 0);
    drive(0, 2, 0, 0, 1);
    chk("t6_restart_read", {31'd0, o_read}, 32'd1);
    chk("t6_restart_addr", o_addr, 32'h60);
    for (int i = 0; i < 4000; i++)
      drive($urandom_range(0, 299) == 0, 2, $urandom_range(0, 15) == 0,
            ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 32'hFFFF)),
            $urandom_range(0, 3) != 0);
    drive(0, 0, 0, 0, 0);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
